// File: rtl/minsec_display_pkg.sv
// Shared types and active-low segment patterns {g,f,e,d,c,b,a} for the min/sec display.
package minsec_display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/minsec_display_seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern, with a dash override.
module seg7_encode
    import minsec_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/minsec_display.sv
// Four-digit multiplexed MM:SS display with dash for out-of-range fields and
// blinking of the field under adjust.
module minsec_display
    import minsec_display_pkg::*;
#(
    parameter int unsigned BASE_CLK     = 100000000,
    parameter int unsigned REFRESH_FREQ = 500,
    parameter int unsigned BLINK_FREQ   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] MINUTES,
    input  logic [5:0] SECONDS,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [3:0] AN,
    output logic [6:0] SEG
);

    localparam int unsigned DIV_R = BASE_CLK / (4 * REFRESH_FREQ);
    localparam int unsigned DIV_B = BASE_CLK / (2 * BLINK_FREQ);
    localparam int unsigned RW    = (DIV_R > 1) ? $clog2(DIV_R) : 1;
    localparam int unsigned BW    = (DIV_B > 1) ? $clog2(DIV_B) : 1;

    logic [RW-1:0] rcnt;
    logic [BW-1:0] bcnt;
    digit_idx_t    idx;
    logic          phase;

    logic          r_tc;
    logic          b_tc;
    logic          phase_nxt;
    digit_idx_t    idx_nxt;
    logic [5:0]    field;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    digit;
    logic          dash;
    logic          blank;
    logic [6:0]    seg_enc;
    logic [3:0]    an_nxt;

    always_comb begin
        r_tc      = (rcnt == RW'(DIV_R - 1));
        b_tc      = (bcnt == BW'(DIV_B - 1));
        phase_nxt = ADJ ? (b_tc ? ~phase : phase) : 1'b1;
        idx_nxt   = idx + 2'd1;
        field     = idx_nxt[1] ? MINUTES : SECONDS;
        tens      = 4'(field / 6'd10);
        ones      = 4'(field % 6'd10);
        digit     = idx_nxt[0] ? tens : ones;
        dash      = (field >= 6'd60);
        // Upper index bit set means a minutes digit; SEL=0 selects minutes.
        // The next phase is used so blanking lines up with the blink toggle edge.
        blank     = ADJ && !phase_nxt && (idx_nxt[1] != SEL);
        an_nxt    = ~(4'b0001 << idx_nxt);
    end

    seg7_encode u_enc (
        .digit (digit),
        .dash  (dash),
        .seg   (seg_enc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rcnt  <= '0;
            bcnt  <= '0;
            idx   <= 2'd0;
            phase <= 1'b1;
            AN    <= 4'b1111;
            SEG   <= SEG_BLANK;
        end else begin
            rcnt  <= r_tc ? '0 : rcnt + 1'b1;
            bcnt  <= (ADJ && !b_tc) ? bcnt + 1'b1 : '0;
            phase <= phase_nxt;
            if (r_tc) begin
                idx <= idx_nxt;
                AN  <= an_nxt;
                SEG <= blank ? SEG_BLANK : seg_enc;
            end
        end
    end

endmodule

// File: tb/tb_minsec_display.sv
// Randomized and directed self-checking bench for minsec_display (DIV_R=4, DIV_B=4).
module tb_minsec_display;

    localparam int DIV_R = 4;
    localparam int DIV_B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] an_seq  [4]  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_seq [4]  = '{7'h30, 7'h24, 7'h79, 7'h19};

    // Reference state: edges since reset, consecutive ADJ=1 edges, expected outputs.
    int         k;
    int         run;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    minsec_display #(
        .BASE_CLK     (16),
        .REFRESH_FREQ (1),
        .BLINK_FREQ   (2)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .MINUTES (minutes),
        .SECONDS (seconds),
        .ADJ     (adj),
        .SEL     (sel),
        .AN      (an),
        .SEG     (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(int kk, int r, logic [5:0] m, logic [5:0] s,
                                             logic a, logic sl);
        int d;
        int v;
        bit visible;
        d       = (kk / DIV_R) % 4;
        v       = (d >= 2) ? int'(m) : int'(s);
        visible = ((r / DIV_B) % 2) == 0;
        if (a && !visible && ((d >= 2) == (sl == 1'b0))) return 7'h7F;
        if (v >= 60) return 7'h3F;
        return seg_tab[(d % 2 == 1) ? v / 10 : v % 10];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= 0;
            run     <= 0;
            exp_an  <= 4'b1111;
            exp_seg <= 7'h7F;
        end else begin
            k   <= k + 1;
            run <= adj ? run + 1 : 0;
            if ((k + 1) % DIV_R == 0) begin
                exp_an  <= ~(4'b0001 << (((k + 1) / DIV_R) % 4));
                exp_seg <= model_seg(k + 1, adj ? run + 1 : 0, minutes, seconds, adj, sel);
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (an !== 4'b1111 || seg !== 7'h7F) begin
            bad++;
            $display("FAIL reset_hold an=%b want 1111 seg=%h want 7f", an, seg);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL reset_release edge=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_scan();
        // Prior task left the scan exactly on a load boundary, at index 1.
        minutes = 6'd12;
        seconds = 6'd34;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL scan cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
            if (i % 4 == 0) begin
                total++;
                if (an !== an_seq[(i / 4) % 4] || seg !== seg_seq[(i / 4) % 4]) begin
                    bad++;
                    $display("FAIL scan_fixed cyc=%0d an=%b want %b seg=%h want %h", i, an,
                             an_seq[(i / 4) % 4], seg, seg_seq[(i / 4) % 4]);
                end
            end
        end
    endtask

    task automatic test_dash();
        minutes = 6'd61;
        seconds = 6'd59;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL dash cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_blink();
        minutes = 6'd12;
        seconds = 6'd34;
        adj     = 1'b1;
        sel     = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL blink cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
            if ((an[3] == 1'b0 || an[2] == 1'b0) && seg === 7'h7F) begin
                total++;
                bad++;
                $display("FAIL blink_minutes cyc=%0d an=%b seg=%h want not 7f", i, an, seg);
            end
        end
    endtask

    task automatic test_sel_toggle();
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            if (i == 6) sel = 1'b0;
            if (i == 22) adj = 1'b0;
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL sel_toggle cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_midscan_reset();
        minutes = 6'd7;
        seconds = 6'd45;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (an !== 4'b1111 || seg !== 7'h7F) begin
            bad++;
            $display("FAIL midscan_reset an=%b want 1111 seg=%h want 7f", an, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL midscan_restart cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) adj = ~adj;
            if ($urandom_range(0, 11) == 0) sel = ~sel;
            total++;
            if (an !== exp_an || seg !== exp_seg) begin
                bad++;
                $display("FAIL random cyc=%0d an=%b want %b seg=%h want %h",
                         i, an, exp_an, seg, exp_seg);
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        minutes = 6'd0;
        seconds = 6'd0;
        adj     = 1'b0;
        sel     = 1'b0;
        #1 rst  = 1'b1;
        test_reset();
        test_scan();
        test_dash();
        test_blink();
        test_sel_toggle();
        test_midscan_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
